// File: rtl/muldiv_unit.sv
// Iterative shared multiply/divide engine: shift-add MULT, restoring DIV, HI/LO result pair.
// Optional MULDIV_EARLY_EXIT_EN lets MULT/MULTU leave RUN once the multiplier is exhausted.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 dz_pend_q, dz_pend_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 op_signed, op_div;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       shifted;
  logic [WIDTH-1:0]     diff;
  logic                 ge;
  logic [WIDTH-1:0]     mplr_next;
  logic [2*WIDTH-1:0]   prod_neg;

  assign op_signed = ~op[0];
  assign op_div    = op[1];
  assign a_neg     = op_signed & src_a[WIDTH-1];
  assign b_neg     = op_signed & src_b[WIDTH-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;

  // Restoring step: partial remainder shifted left with the next dividend bit appended.
  assign shifted   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge        = shifted >= {1'b0, mcand_q[WIDTH-1:0]};
  assign diff      = shifted[WIDTH-1:0] - mcand_q[WIDTH-1:0];
  assign mplr_next = mplr_q >> 1;
  assign prod_neg  = -acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    dz_pend_d = 1'b0;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (dz_pend_q) begin
      done_d = 1'b1;
      dz_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op_div && (src_b == '0)) begin
            dz_pend_d = 1'b1;
          end else begin
            is_div_d = op_div;
            cnt_d    = CNT_W'(WIDTH);
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            state_d  = StRun;
            if (op_div) begin
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              mcand_d = {{WIDTH{1'b0}}, b_mag};
            end else begin
              acc_d   = '0;
              mcand_d = {{WIDTH{1'b0}}, a_mag};
              mplr_d  = b_mag;
`ifdef MULDIV_EARLY_EXIT_EN
              if (b_mag == '0) state_d = StFix;
`endif
            end
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          acc_d[2*WIDTH-1:WIDTH] = ge ? diff : shifted[WIDTH-1:0];
          acc_d[WIDTH-1:0]       = {acc_q[WIDTH-2:0], ge};
        end else begin
          acc_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_next;
        end
        if (cnt_q == CNT_W'(1)) state_d = StFix;
`ifdef MULDIV_EARLY_EXIT_EN
        if (!is_div_q && (mplr_next == '0)) state_d = StFix;
`endif
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_lo_q ? prod_neg : acc_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      dz_pend_q <= dz_pend_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Drive a request so that it is sampled at edge 0; returns 1ns after edge 0.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges from 'first' until done is seen; e = -1 on timeout.
  task automatic wait_done(input int first, output int e, output logic busy_all);
    e = -1;
    busy_all = 1'b1;
    for (int k = first; k < first + 45; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        e = k;
        break;
      end
      if (!busy) busy_all = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {busy, done, div_zero});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h want 0", {hi, lo});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int e;
    logic ba;
    start_op(OpMult, 32'hFFFF_FFFF, 32'd5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mult_busy_edge0: got %b want 1", busy);
    end
    wait_done(1, e, ba);
    checks++;
    if (e != 33) begin
      errors++;
      $display("FAIL mult_latency: got %0d want 33", e);
    end
    checks++;
    if (ba !== 1'b1) begin
      errors++;
      $display("FAIL mult_busy_run: got %b want 1", ba);
    end
    checks++;
    if ({busy, div_zero} !== 2'b00) begin
      errors++;
      $display("FAIL mult_done_flags: got %b want 00", {busy, div_zero});
    end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFB) begin
      errors++;
      $display("FAIL mult_neg5: got %h want ffffffff_fffffffb", {hi, lo});
    end
    start_op(OpMult, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
    wait_done(1, e, ba);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_000C) begin
      errors++;
      $display("FAIL mult_negneg: got %h want 00000000_0000000c", {hi, lo});
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got %b want 0", done);
    end
  endtask

  task automatic test_multu;
    int e;
    logic ba;
    start_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, e, ba);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL multu_max: got %h want fffffffe_00000001", {hi, lo});
    end
  endtask

  task automatic test_div;
    int e;
    logic ba;
    start_op(OpDiv, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, e, ba);
    checks++;
    if (e != 33) begin
      errors++;
      $display("FAIL div_latency: got %0d want 33", e);
    end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL div_m7_2: got %h want ffffffff_fffffffd", {hi, lo});
    end
    start_op(OpDivu, 32'd7, 32'd2);
    wait_done(1, e, ba);
    checks++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003) begin
      errors++;
      $display("FAIL divu_7_2: got %h want 00000001_00000003", {hi, lo});
    end
    start_op(OpDiv, 32'd7, 32'hFFFF_FFFE);
    wait_done(1, e, ba);
    checks++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin
      errors++;
      $display("FAIL div_7_m2: got %h want 00000001_fffffffd", {hi, lo});
    end
    start_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, e, ba);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL div_minint: got %h want 00000000_80000000", {hi, lo});
    end
  endtask

  task automatic test_div_zero;
    int e;
    logic ba;
    start_op(OpDivu, 32'd7, 32'd0);
    wait_done(1, e, ba);
    checks++;
    if (e != 1) begin
      errors++;
      $display("FAIL divzero_latency: got %0d want 1", e);
    end
    checks++;
    if (div_zero !== 1'b1) begin
      errors++;
      $display("FAIL divzero_flag: got %b want 1", div_zero);
    end
    checks++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL divzero_hold: got %h want 00000000_80000000", {hi, lo});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, div_zero} !== 2'b00) begin
      errors++;
      $display("FAIL divzero_pulse: got %b want 00", {done, div_zero});
    end
  endtask

  task automatic test_start_ignored;
    int e;
    logic ba;
    start_op(OpMultu, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op    = OpDivu;
    src_a = 32'd100;
    src_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, e, ba);
    checks++;
    if (e != 33) begin
      errors++;
      $display("FAIL ignore_latency: got %0d want 33", e);
    end
    checks++;
    if ({hi, lo} !== 64'd42) begin
      errors++;
      $display("FAIL ignore_result: got %h want 2a", {hi, lo});
    end
  endtask

  task automatic test_back_to_back;
    int e;
    logic ba;
    start_op(OpMultu, 32'd9, 32'd9);
    wait_done(1, e, ba);
    // Request raised while done is high; sampled at the edge that ends the done cycle.
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_seen: got %b want 1", done);
    end
    start_op(OpDivu, 32'd100, 32'd7);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got %b want 1", busy);
    end
    wait_done(1, e, ba);
    checks++;
    if ({hi, lo} !== 64'h0000_0002_0000_000E) begin
      errors++;
      $display("FAIL b2b_result: got %h want 00000002_0000000e", {hi, lo});
    end
  endtask

  task automatic test_reset_mid;
    int e;
    logic ba;
    start_op(OpMultu, 32'd5, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({busy, done, hi, lo} !== {2'b00, 64'h0}) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b hilo=%h want 0", busy, done, {hi, lo});
    end
    wait_done(11, e, ba);
    checks++;
    if (e != -1) begin
      errors++;
      $display("FAIL reset_mid_nodone: got done at edge %0d want none", e);
    end
  endtask

  task automatic test_early_exit;
    int e;
    logic ba;
    int want;
`ifdef MULDIV_EARLY_EXIT_EN
    want = 3;
`else
    want = 33;
`endif
    start_op(OpMultu, 32'd3, 32'd2);
    wait_done(1, e, ba);
    checks++;
    if (e != want) begin
      errors++;
      $display("FAIL early_latency: got %0d want %0d", e, want);
    end
    checks++;
    if ({hi, lo} !== 64'd6) begin
      errors++;
      $display("FAIL early_result: got %h want 6", {hi, lo});
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    test_early_exit;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
